// File: rtl/cmos_minterm_cell.sv
// Registered behavioural model of a 4-input static CMOS complex gate.
// The pull-down network is one series chain per set bit of TRUTH and the
// pull-up network is one series group per set bit; both are elaborated
// from TRUTH term by term rather than read from a single table lookup.
module cmos_minterm_cell #(
    parameter logic [15:0] TRUTH = 16'h34CD
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic y,
    output logic pu_on,
    output logic pd_on,
    output logic fault
);

    localparam int unsigned N_IN      = 4;
    localparam int unsigned N_MINTERM = 16;

    logic [N_IN-1:0]      idx_c;
    logic [N_MINTERM-1:0] chain_c;
    logic [N_MINTERM-1:0] group_c;
    logic                 pd_c;
    logic                 pu_c;
    logic                 n_c;
    logic                 y_c;

    assign idx_c = {a, b, c, d};

    // Per-minterm transistor networks; absent minterms contribute no devices
    // (chain open, group shorted) so network size follows popcount(TRUTH).
    for (genvar i = 0; i < N_MINTERM; i++) begin : g_minterm
        if (TRUTH[i]) begin : g_present
            // Four series NMOS conduct only when every literal matches.
            assign chain_c[i] = (idx_c == N_IN'(i));
            // Four parallel PMOS block only when every literal matches.
            assign group_c[i] = (idx_c != N_IN'(i));
        end else begin : g_absent
            assign chain_c[i] = 1'b0;
            assign group_c[i] = 1'b1;
        end
    end

    // Parallel chains OR together; series groups AND together.
    always_comb begin
        pd_c = |chain_c;
        pu_c = &group_c;
        // Internal node: high when pulled up, otherwise low.
        n_c  = pu_c;
        y_c  = ~n_c;
    end

    // Output register with sticky complementarity monitor.
    always_ff @(posedge clk) begin
        if (rst) begin
            y     <= 1'b0;
            pu_on <= 1'b0;
            pd_on <= 1'b0;
            fault <= 1'b0;
        end else begin
            y     <= y_c;
            pu_on <= pu_c;
            pd_on <= pd_c;
            fault <= fault | (pu_c == pd_c);
        end
    end

endmodule

// File: tb/tb_cmos_minterm_cell.sv
// Directed bench for cmos_minterm_cell: default TRUTH and a TRUTH=16'h8000 copy.
module tb_cmos_minterm_cell;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic y, pu_on, pd_on, fault;
    logic y2, pu_on2, pd_on2, fault2;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    cmos_minterm_cell dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
        .y(y), .pu_on(pu_on), .pd_on(pd_on), .fault(fault)
    );

    cmos_minterm_cell #(.TRUTH(16'h8000)) dut_ovr (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
        .y(y2), .pu_on(pu_on2), .pd_on(pd_on2), .fault(fault2)
    );

    // Expected y for the default gate, minterm 0 first, from the truth table listing.
    int exp_default [16] = '{1,0,1,1,0,0,1,1,0,0,1,0,1,1,0,0};

    task automatic set_in(input logic [3:0] v);
        {a, b, c, d} = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        rst = 1'b1;
        set_in(4'b1111);
        for (int k = 0; k < 2; k++) begin
            tick();
            obs = {y, pu_on, pd_on, fault};
            n_vec++;
            if (obs !== 4'b0000) begin
                n_miss++;
                $display("FAIL reset_default cycle %0d: got {y,pu,pd,fault}=%b want 0000", k, obs);
            end
            obs = {y2, pu_on2, pd_on2, fault2};
            n_vec++;
            if (obs !== 4'b0000) begin
                n_miss++;
                $display("FAIL reset_override cycle %0d: got {y,pu,pd,fault}=%b want 0000", k, obs);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_sweep();
        logic [3:0] obs;
        logic [3:0] want;
        logic       e;
        for (int i = 0; i < 16; i++) begin
            set_in(4'(i));
            tick();
            e    = (exp_default[i] != 0);
            want = {e, ~e, e, 1'b0};
            obs  = {y, pu_on, pd_on, fault};
            n_vec++;
            if (obs !== want) begin
                n_miss++;
                $display("FAIL sweep_default idx %0d: got {y,pu,pd,fault}=%b want %b", i, obs, want);
            end
            e    = (i == 15);
            want = {e, ~e, e, 1'b0};
            obs  = {y2, pu_on2, pd_on2, fault2};
            n_vec++;
            if (obs !== want) begin
                n_miss++;
                $display("FAIL sweep_override idx %0d: got {y,pu,pd,fault}=%b want %b", i, obs, want);
            end
        end
    endtask

    task automatic test_latency();
        set_in(4'b0001);
        tick();
        n_vec++;
        if (y !== 1'b0) begin
            n_miss++;
            $display("FAIL latency_settle: got y=%b want 0", y);
        end
        set_in(4'b0000);
        #3;
        n_vec++;
        if (y !== 1'b0) begin
            n_miss++;
            $display("FAIL latency_early: got y=%b want 0 before edge", y);
        end
        tick();
        n_vec++;
        if (y !== 1'b1) begin
            n_miss++;
            $display("FAIL latency_edge: got y=%b want 1", y);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] obs;
        set_in(4'b1100);
        tick();
        n_vec++;
        if (y !== 1'b1) begin
            n_miss++;
            $display("FAIL mid_pre: got y=%b want 1", y);
        end
        rst = 1'b1;
        tick();
        obs = {y, pu_on, pd_on, fault};
        n_vec++;
        if (obs !== 4'b0000) begin
            n_miss++;
            $display("FAIL mid_reset: got {y,pu,pd,fault}=%b want 0000", obs);
        end
        rst = 1'b0;
        tick();
        obs = {y, pu_on, pd_on, fault};
        n_vec++;
        if (obs !== 4'b1010) begin
            n_miss++;
            $display("FAIL mid_release: got {y,pu,pd,fault}=%b want 1010", obs);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] vecs [6] = '{4'd15, 4'd0, 4'd13, 4'd4, 4'd10, 4'd11};
        logic       wy   [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic       wy2  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            set_in(vecs[i]);
            tick();
            n_vec++;
            if ({y, pu_on, pd_on} !== {wy[i], ~wy[i], wy[i]}) begin
                n_miss++;
                $display("FAIL b2b_default step %0d: got {y,pu,pd}=%b%b%b want y=%b",
                         i, y, pu_on, pd_on, wy[i]);
            end
            n_vec++;
            if ({y2, pd_on2} !== {wy2[i], wy2[i]}) begin
                n_miss++;
                $display("FAIL b2b_override step %0d: got {y,pd}=%b%b want %b", i, y2, pd_on2, wy2[i]);
            end
        end
        n_vec++;
        if ({fault, fault2} !== 2'b00) begin
            n_miss++;
            $display("FAIL b2b_fault: got fault=%b%b want 00", fault, fault2);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_latency();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
